// File: rtl/asic_pkg.sv
// Shared types and constants for the accelerator tile scheduler.
// The scheduler owns the load, compute and readout sequencing.
package asic_pkg;

   localparam int IFMAP_WORDS  = 16;
   localparam int WEIGHT_WORDS = 1024;
   localparam int BIAS_WORDS   = 64;
   localparam int NUM_TILES    = 2;
   localparam int OFMAP_WORDS  = NUM_TILES * BIAS_WORDS;

   localparam int LD_CNT_W = $clog2(WEIGHT_WORDS);
   localparam int RD_CNT_W = $clog2(OFMAP_WORDS);
   // One extra code so the index can step past the final tile before readout.
   localparam int TILE_W   = $clog2(NUM_TILES + 1);

   localparam int CFG_SCALE_LSB = 4;
   localparam int CFG_SCALE_W   = 16;
   localparam int CFG_EN_BIT    = 3;
   localparam int CFG_MODE_LSB  = 0;
   localparam int CFG_MODE_W    = 2;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      LD_IFMAP  = 3'd1,
      LD_WEIGHT = 3'd2,
      LD_BIAS   = 3'd3,
      COMPUTE   = 3'd4,
      READOUT   = 3'd5
   } sched_state_e;

endpackage

// File: rtl/sched_word_counter.sv
// Word counter with synchronous clear, advance, and a last-word flag.
// It wraps to zero when it advances from the programmed last value.
module sched_word_counter #(
   parameter int W = 10
) (
   input  logic         ACLK,
   input  logic         ARESETn,
   input  logic         clr,
   input  logic         adv,
   input  logic [W-1:0] last_val,
   output logic [W-1:0] count,
   output logic         last
);

   assign last = (count == last_val);

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (adv) begin
         count <= last ? '0 : count + W'(1);
      end
   end

endmodule

// File: rtl/asic_tile_scheduler.sv
// Tile scheduler: streams ifmap, weight and bias words into their SRAMs,
// starts compute per tile, raises the interrupt, then walks ofmap readout.
// Handshakes: a transfer happens on a rising edge where valid and ready are both high.
// Ready never depends on valid. cfg, dat and rd each have one such channel.
module asic_tile_scheduler import asic_pkg::*; (
   input  logic         ACLK,
   input  logic         ARESETn,
   input  logic         cfg_valid,
   input  logic [31:0]  cfg_data,
   output logic         cfg_ready,
   input  logic         dat_valid,
   input  logic [31:0]  dat_wdata,
   output logic         dat_ready,
   input  logic         rd_valid_in,
   output logic         rd_ready,
   output logic         rd_rsp_valid,
   output logic [31:0]  mem_wdata,
   output logic         ifmap_we,
   output logic         weight_we,
   output logic         bias_we,
   output logic [9:0]   mem_waddr,
   output logic         ofmap_re,
   output logic [6:0]   ofmap_raddr,
   output logic [6:0]   ofmap_base,
   output logic [15:0]  scale,
   output logic [1:0]   mode,
   output logic         comp_start,
   input  logic         comp_done,
   output logic         ASIC_interrupt,
   output sched_state_e state_dbg
);

   sched_state_e        state, state_nxt;
   logic                dat_acc, rd_acc, done_acc;
   logic [LD_CNT_W-1:0] ld_cnt, ld_last_val;
   logic                ld_last;
   logic [RD_CNT_W-1:0] rd_cnt;
   logic                rd_last;
   logic [TILE_W-1:0]   tile_idx;
   logic                bias_last_q, rd_last_q;
   logic                unused_cfg;

   assign state_dbg  = state;
   assign dat_acc    = dat_valid && dat_ready;
   assign rd_acc     = rd_valid_in && rd_ready;
   assign done_acc   = comp_done && (state == COMPUTE);
   assign unused_cfg = ^{cfg_data[31:20], cfg_data[2]};

   sched_word_counter #(.W(LD_CNT_W)) u_ld_cnt (
      .ACLK     (ACLK),
      .ARESETn  (ARESETn),
      .clr      (state == IDLE),
      .adv      (dat_acc),
      .last_val (ld_last_val),
      .count    (ld_cnt),
      .last     (ld_last)
   );

   sched_word_counter #(.W(RD_CNT_W)) u_rd_cnt (
      .ACLK     (ACLK),
      .ARESETn  (ARESETn),
      .clr      (state != READOUT),
      .adv      (rd_acc),
      .last_val (RD_CNT_W'(OFMAP_WORDS - 1)),
      .count    (rd_cnt),
      .last     (rd_last)
   );

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:      if (cfg_valid && cfg_data[CFG_EN_BIT]) state_nxt = LD_IFMAP;
         LD_IFMAP:  if (dat_acc && ld_last) state_nxt = LD_WEIGHT;
         LD_WEIGHT: if (dat_acc && ld_last) state_nxt = LD_BIAS;
         LD_BIAS:   if (dat_acc && ld_last) state_nxt = COMPUTE;
         COMPUTE:   if (comp_done)
                       state_nxt = (tile_idx == TILE_W'(NUM_TILES - 1)) ? READOUT : LD_IFMAP;
         READOUT:   if (rd_rsp_valid && rd_last_q) state_nxt = IDLE;
         default:   state_nxt = IDLE;
      endcase
   end

   always_comb begin
      cfg_ready   = (state == IDLE);
      dat_ready   = (state == LD_IFMAP) || (state == LD_WEIGHT) || (state == LD_BIAS);
      // A single read may be outstanding, so the response cycle blocks a new request.
      rd_ready    = (state == READOUT) && !rd_rsp_valid;
      ofmap_re    = rd_valid_in && rd_ready;
      ofmap_raddr = rd_cnt;
      ofmap_base  = RD_CNT_W'(32'(tile_idx) * BIAS_WORDS);
      ld_last_val = '0;
      case (state)
         LD_IFMAP:  ld_last_val = LD_CNT_W'(IFMAP_WORDS - 1);
         LD_WEIGHT: ld_last_val = LD_CNT_W'(WEIGHT_WORDS - 1);
         LD_BIAS:   ld_last_val = LD_CNT_W'(BIAS_WORDS - 1);
         default:   ld_last_val = '0;
      endcase
   end

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         mem_wdata      <= '0;
         mem_waddr      <= '0;
         ifmap_we       <= 1'b0;
         weight_we      <= 1'b0;
         bias_we        <= 1'b0;
         bias_last_q    <= 1'b0;
         comp_start     <= 1'b0;
         rd_rsp_valid   <= 1'b0;
         rd_last_q      <= 1'b0;
         scale          <= '0;
         mode           <= '0;
         tile_idx       <= '0;
         ASIC_interrupt <= 1'b0;
      end else begin
         ifmap_we     <= dat_acc && (state == LD_IFMAP);
         weight_we    <= dat_acc && (state == LD_WEIGHT);
         bias_we      <= dat_acc && (state == LD_BIAS);
         if (dat_acc) begin
            mem_wdata <= dat_wdata;
            mem_waddr <= ld_cnt;
         end
         // Start compute only once the final bias word has reached its SRAM.
         bias_last_q  <= dat_acc && (state == LD_BIAS) && ld_last;
         comp_start   <= bias_last_q;
         rd_rsp_valid <= rd_acc;
         rd_last_q    <= rd_acc && rd_last;
         if (cfg_valid && cfg_ready) begin
            scale <= cfg_data[CFG_SCALE_LSB +: CFG_SCALE_W];
            mode  <= cfg_data[CFG_MODE_LSB +: CFG_MODE_W];
         end
         if (state_nxt == IDLE) tile_idx <= '0;
         else if (done_acc)     tile_idx <= tile_idx + TILE_W'(1);
         if (done_acc)                ASIC_interrupt <= 1'b1;
         else if (dat_acc || rd_acc)  ASIC_interrupt <= 1'b0;
      end
   end

endmodule
